// File: rtl/mem_responder.sv
// Word-addressed memory responder: in-order responses after a fixed LATENCY, bounded by RSP_Q_DEPTH outstanding.
// Optional build macro MEM_RESPONDER_RAND_STALL_EN adds LFSR-driven random req_rdy stalls.
package mem_responder_pkg;
    typedef enum logic [0:0] {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_op_e;

    typedef struct packed {
        mem_op_e     mtype;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_pkt_t;

    localparam logic [1:0] LEN_WORD = 2'd0;
    localparam logic [1:0] LEN_BYTE = 2'd1;
    localparam logic [1:0] LEN_HALF = 2'd2;
endpackage

// Generic ordered queue; head_dat is valid whenever empty is low.
// Latency: one cycle push-to-head; backpressure: caller must not overfill it.
// Pop only while non-empty.
module mem_responder_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_rdy,
    output logic [W-1:0] head_dat,
    output logic         empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  buf_q [DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    logic [CW-1:0] cnt_q;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_vld) wr_q <= ptr_next(wr_q);
            if (pop_rdy)  rd_q <= ptr_next(rd_q);
            cnt_q <= cnt_q + CW'(push_vld) - CW'(pop_rdy);
        end
    end

    always_ff @(posedge clk) begin
        if (push_vld) buf_q[wr_q] <= push_dat;
    end

    assign head_dat = buf_q[rd_q];
    assign empty    = (cnt_q == '0);
endmodule

// Memory responder top: accepts one request per cycle, answers every request in order.
// Latency: LATENCY cycles when the response queue is empty; backpressure via outstanding-count req_rdy.
// Feature macro: MEM_RESPONDER_RAND_STALL_EN (random request stalls).
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1,
    parameter int RSP_Q_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     req_vld,
    output logic     req_rdy,
    input  mem_pkt_t req,
    output logic     rsp_vld,
    input  logic     rsp_rdy,
    output mem_pkt_t rsp
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(RSP_Q_DEPTH + 1);
    localparam int PW = $bits(mem_pkt_t);

    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          acc;
    logic          retire;
    logic          stall;
    logic [AW-1:0] idx;
    logic [31:0]   cur_word;
    logic [31:0]   rd_data;
    logic [31:0]   wr_word;
    mem_pkt_t      acc_pkt;
    logic          push_vld;
    mem_pkt_t      push_pkt;
    logic [PW-1:0] q_head;
    logic          q_empty;
    logic          unused_addr_bits;

    assign acc      = req_vld && req_rdy;
    assign retire   = rsp_vld && rsp_rdy;
    assign idx      = req.addr[AW+1:2];
    assign cur_word = mem_q[idx];
    assign unused_addr_bits = ^req.addr[31:AW+2];

`ifdef MEM_RESPONDER_RAND_STALL_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= 16'hACE1;
        else     lfsr_q <= lfsr_d;
    end

    assign stall = lfsr_q[0];
`else
    assign stall = 1'b0;
`endif

    // Count covers both pipeline and queue, so the queue can never overflow.
    assign req_rdy = !rst && (cnt_q < CW'(RSP_Q_DEPTH)) && !stall;

    always_comb begin
        cnt_d = cnt_q;
        case ({acc, retire})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    always_comb begin
        rd_data = cur_word;
        wr_word = req.data;
        case (req.len)
            LEN_BYTE: begin
                rd_data = {24'b0, cur_word[{req.addr[1:0], 3'b000} +: 8]};
                wr_word = cur_word;
                wr_word[{req.addr[1:0], 3'b000} +: 8] = req.data[7:0];
            end
            LEN_HALF: begin
                rd_data = {16'b0, cur_word[{req.addr[1], 4'b0000} +: 16]};
                wr_word = cur_word;
                wr_word[{req.addr[1], 4'b0000} +: 16] = req.data[15:0];
            end
            default: begin
                rd_data = cur_word;
                wr_word = req.data;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (acc && req.mtype == MEM_WRITE) mem_q[idx] <= wr_word;
    end

    always_comb begin
        acc_pkt       = req;
        acc_pkt.data  = (req.mtype == MEM_READ) ? rd_data : 32'b0;
    end

    generate
        if (LATENCY == 1) begin : g_nopipe
            assign push_vld = acc;
            assign push_pkt = acc_pkt;
        end else begin : g_pipe
            logic [LATENCY-2:0] vld_q;
            mem_pkt_t           pkt_q [LATENCY-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q <= '0;
                end else begin
                    vld_q[0] <= acc;
                    for (int i = 1; i < LATENCY - 1; i++) vld_q[i] <= vld_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                pkt_q[0] <= acc_pkt;
                for (int i = 1; i < LATENCY - 1; i++) pkt_q[i] <= pkt_q[i-1];
            end

            assign push_vld = vld_q[LATENCY-2];
            assign push_pkt = pkt_q[LATENCY-2];
        end
    endgenerate

    mem_responder_fifo #(
        .W     (PW),
        .DEPTH (RSP_Q_DEPTH)
    ) u_rsp_q (
        .clk      (clk),
        .rst      (rst),
        .push_vld (push_vld),
        .push_dat (push_pkt),
        .pop_rdy  (retire),
        .head_dat (q_head),
        .empty    (q_empty)
    );

    assign rsp_vld = !rst && !q_empty;
    assign rsp     = rsp_vld ? mem_pkt_t'(q_head) : '0;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: instance A uses defaults (LATENCY=1), instance B uses LATENCY=3.
module tb_mem_responder;
    import mem_responder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    int   n_run = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic     a_req_vld, a_req_rdy, a_rsp_vld, a_rsp_rdy;
    mem_pkt_t a_req, a_rsp;
    logic     b_req_vld, b_req_rdy, b_rsp_vld, b_rsp_rdy;
    mem_pkt_t b_req, b_rsp;

    mem_pkt_t a_rsp_q[$];
    int       a_rsp_cyc[$];
    int       a_acc_cyc[$];
    mem_pkt_t b_rsp_q[$];
    int       b_rsp_cyc[$];
    int       b_acc_cyc[$];

    mem_responder u_dut_a (
        .clk     (clk),
        .rst     (rst),
        .req_vld (a_req_vld),
        .req_rdy (a_req_rdy),
        .req     (a_req),
        .rsp_vld (a_rsp_vld),
        .rsp_rdy (a_rsp_rdy),
        .rsp     (a_rsp)
    );

    mem_responder #(.DEPTH_WORDS(1024), .LATENCY(3), .RSP_Q_DEPTH(4)) u_dut_b (
        .clk     (clk),
        .rst     (rst),
        .req_vld (b_req_vld),
        .req_rdy (b_req_rdy),
        .req     (b_req),
        .rsp_vld (b_rsp_vld),
        .rsp_rdy (b_rsp_rdy),
        .rsp     (b_rsp)
    );

    always @(negedge clk) begin
        if (a_req_vld && a_req_rdy) a_acc_cyc.push_back(cyc);
        if (a_rsp_vld && a_rsp_rdy) begin
            a_rsp_q.push_back(a_rsp);
            a_rsp_cyc.push_back(cyc);
        end
        if (b_req_vld && b_req_rdy) b_acc_cyc.push_back(cyc);
        if (b_rsp_vld && b_rsp_rdy) begin
            b_rsp_q.push_back(b_rsp);
            b_rsp_cyc.push_back(cyc);
        end
    end

    task automatic clear_logs();
        a_rsp_q.delete(); a_rsp_cyc.delete(); a_acc_cyc.delete();
        b_rsp_q.delete(); b_rsp_cyc.delete(); b_acc_cyc.delete();
    endtask

    task automatic send_a(input mem_op_e t, input logic [31:0] ad, input logic [1:0] ln, input logic [31:0] dt);
        a_req     = '{mtype: t, addr: ad, len: ln, data: dt};
        a_req_vld = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (a_req_rdy) begin
                @(posedge clk); #1;
                a_req_vld = 1'b0;
                return;
            end
        end
        n_run++; n_fail++;
        $display("FAIL send_a_timeout addr=%h: req_rdy stayed 0, want 1 within 50 cycles", ad);
        a_req_vld = 1'b0;
    endtask

    task automatic send_b(input mem_op_e t, input logic [31:0] ad, input logic [1:0] ln, input logic [31:0] dt);
        b_req     = '{mtype: t, addr: ad, len: ln, data: dt};
        b_req_vld = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (b_req_rdy) begin
                @(posedge clk); #1;
                b_req_vld = 1'b0;
                return;
            end
        end
        n_run++; n_fail++;
        $display("FAIL send_b_timeout addr=%h: req_rdy stayed 0, want 1 within 50 cycles", ad);
        b_req_vld = 1'b0;
    endtask

    task automatic wait_rsp_a(input int n);
        for (int k = 0; k < 100; k++) begin
            if (a_rsp_q.size() >= n) return;
            @(negedge clk);
        end
        n_run++; n_fail++;
        $display("FAIL wait_rsp_a: got %0d responses, want %0d", a_rsp_q.size(), n);
    endtask

    task automatic wait_rsp_b(input int n);
        for (int k = 0; k < 100; k++) begin
            if (b_rsp_q.size() >= n) return;
            @(negedge clk);
        end
        n_run++; n_fail++;
        $display("FAIL wait_rsp_b: got %0d responses, want %0d", b_rsp_q.size(), n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_run++; if (a_req_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_req_rdy got %b want 0", a_req_rdy); end
        n_run++; if (a_rsp_vld !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_vld got %b want 0", a_rsp_vld); end
        n_run++; if (a_rsp !== '0) begin n_fail++; $display("FAIL rst_rsp got %h want 0", a_rsp); end
        n_run++; if (b_req_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_b_req_rdy got %b want 0", b_req_rdy); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_run++; if (a_req_rdy !== 1'b1) begin n_fail++; $display("FAIL post_rst_req_rdy got %b want 1", a_req_rdy); end
        n_run++; if (b_req_rdy !== 1'b1) begin n_fail++; $display("FAIL post_rst_b_req_rdy got %b want 1", b_req_rdy); end
        n_run++; if (a_rsp_vld !== 1'b0) begin n_fail++; $display("FAIL post_rst_rsp_vld got %b want 0", a_rsp_vld); end
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        clear_logs();
        a_rsp_rdy = 1'b1;
        send_a(MEM_WRITE, 32'h10, LEN_WORD, 32'hDEADBEEF);
        send_a(MEM_READ,  32'h10, LEN_WORD, 32'h0);
        wait_rsp_a(2);
        n_run++; if (a_rsp_q[0].mtype !== MEM_WRITE || a_rsp_q[0].addr !== 32'h10 || a_rsp_q[0].data !== 32'h0)
            begin n_fail++; $display("FAIL wr_rsp got %h want {W,10,0,0}", a_rsp_q[0]); end
        n_run++; if (a_rsp_q[1].mtype !== MEM_READ || a_rsp_q[1].data !== 32'hDEADBEEF)
            begin n_fail++; $display("FAIL rd_rsp_data got %h want DEADBEEF", a_rsp_q[1].data); end
        n_run++; if (a_rsp_cyc[0] - a_acc_cyc[0] !== 1)
            begin n_fail++; $display("FAIL lat1_first got %0d want 1", a_rsp_cyc[0] - a_acc_cyc[0]); end
        n_run++; if (a_rsp_cyc[1] - a_acc_cyc[1] !== 1)
            begin n_fail++; $display("FAIL lat1_second got %0d want 1", a_rsp_cyc[1] - a_acc_cyc[1]); end
        @(posedge clk); #1;
    endtask

    task automatic test_byte_lanes();
        clear_logs();
        a_rsp_rdy = 1'b1;
        send_a(MEM_WRITE, 32'h10, LEN_WORD, 32'h0);
        send_a(MEM_WRITE, 32'h13, LEN_BYTE, 32'hFFFFFFA5);
        send_a(MEM_READ,  32'h12, LEN_HALF, 32'h0);
        send_a(MEM_READ,  32'h13, LEN_BYTE, 32'h0);
        send_a(MEM_WRITE, 32'h14, LEN_WORD, 32'h11223344);
        send_a(MEM_WRITE, 32'h15, LEN_HALF, 32'hFFFFBEEF);
        send_a(MEM_READ,  32'h14, 2'd3,     32'h0);
        send_a(MEM_READ,  32'h16, LEN_BYTE, 32'h0);
        wait_rsp_a(8);
        n_run++; if (a_rsp_q[2].data !== 32'h0000A500) begin n_fail++; $display("FAIL half_rd got %h want 0000A500", a_rsp_q[2].data); end
        n_run++; if (a_rsp_q[2].len !== LEN_HALF || a_rsp_q[2].addr !== 32'h12)
            begin n_fail++; $display("FAIL half_rd_fields got len=%0d addr=%h want len=2 addr=12", a_rsp_q[2].len, a_rsp_q[2].addr); end
        n_run++; if (a_rsp_q[3].data !== 32'h000000A5) begin n_fail++; $display("FAIL byte_rd got %h want 000000A5", a_rsp_q[3].data); end
        n_run++; if (a_rsp_q[6].data !== 32'h1122BEEF) begin n_fail++; $display("FAIL len3_rd got %h want 1122BEEF", a_rsp_q[6].data); end
        n_run++; if (a_rsp_q[7].data !== 32'h00000022) begin n_fail++; $display("FAIL byte2_rd got %h want 00000022", a_rsp_q[7].data); end
        n_run++; if (a_rsp_q[5].mtype !== MEM_WRITE || a_rsp_q[5].data !== 32'h0)
            begin n_fail++; $display("FAIL half_wr_rsp got %h want write with data 0", a_rsp_q[5]); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        mem_pkt_t held;
        int       rdy_seen;
        int       unstable;
        clear_logs();
        a_rsp_rdy = 1'b0;
        for (int i = 0; i < 4; i++) send_a(MEM_READ, 32'h10 + 32'(4 * i), LEN_WORD, 32'h0);
        a_req     = '{mtype: MEM_READ, addr: 32'h20, len: LEN_WORD, data: 32'h0};
        a_req_vld = 1'b1;
        rdy_seen  = 0;
        unstable  = 0;
        @(negedge clk);
        held = a_rsp;
        for (int i = 0; i < 6; i++) begin
            if (a_req_rdy !== 1'b0) rdy_seen++;
            if (a_rsp !== held) unstable++;
            @(negedge clk);
        end
        n_run++; if (rdy_seen !== 0) begin n_fail++; $display("FAIL full_req_rdy got %0d ready cycles want 0", rdy_seen); end
        n_run++; if (unstable !== 0) begin n_fail++; $display("FAIL rsp_stable got %0d changes want 0", unstable); end
        n_run++; if (a_acc_cyc.size() !== 4) begin n_fail++; $display("FAIL accept_count got %0d want 4", a_acc_cyc.size()); end
        n_run++; if (held.addr !== 32'h10) begin n_fail++; $display("FAIL held_head got %h want 10", held.addr); end
        @(posedge clk); #1;
        a_req_vld = 1'b0;
        a_rsp_rdy = 1'b1;
        @(negedge clk);
        n_run++; if (a_req_rdy !== 1'b0) begin n_fail++; $display("FAIL rdy_at_retire got %b want 0", a_req_rdy); end
        @(negedge clk);
        n_run++; if (a_req_rdy !== 1'b1) begin n_fail++; $display("FAIL rdy_after_retire got %b want 1", a_req_rdy); end
        wait_rsp_a(4);
        for (int i = 0; i < 4; i++) begin
            n_run++;
            if (a_rsp_q[i].addr !== 32'h10 + 32'(4 * i))
                begin n_fail++; $display("FAIL bp_order[%0d] got %h want %h", i, a_rsp_q[i].addr, 32'h10 + 32'(4 * i)); end
        end
        n_run++; if (a_rsp_q[1].data !== 32'h1122BEEF) begin n_fail++; $display("FAIL bp_data got %h want 1122BEEF", a_rsp_q[1].data); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int gaps;
        clear_logs();
        b_rsp_rdy = 1'b1;
        for (int i = 0; i < 8; i++) send_b(MEM_READ, 32'h100 + 32'(4 * i), LEN_WORD, 32'h0);
        wait_rsp_b(8);
        n_run++; if (b_acc_cyc[7] - b_acc_cyc[0] !== 7) begin n_fail++; $display("FAIL b2b_accept_span got %0d want 7", b_acc_cyc[7] - b_acc_cyc[0]); end
        n_run++; if (b_rsp_cyc[0] - b_acc_cyc[0] !== 3) begin n_fail++; $display("FAIL lat3_first got %0d want 3", b_rsp_cyc[0] - b_acc_cyc[0]); end
        gaps = 0;
        for (int i = 1; i < 8; i++) if (b_rsp_cyc[i] - b_rsp_cyc[i-1] != 1) gaps++;
        n_run++; if (gaps !== 0) begin n_fail++; $display("FAIL b2b_bubbles got %0d want 0", gaps); end
        for (int i = 0; i < 8; i++) begin
            n_run++;
            if (b_rsp_q[i].addr !== 32'h100 + 32'(4 * i) || b_rsp_q[i].mtype !== MEM_READ)
                begin n_fail++; $display("FAIL b2b_order[%0d] got %h want %h", i, b_rsp_q[i].addr, 32'h100 + 32'(4 * i)); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midflight();
        clear_logs();
        a_rsp_rdy = 1'b0;
        send_a(MEM_WRITE, 32'h40, LEN_WORD, 32'hCAFEF00D);
        send_a(MEM_READ,  32'h40, LEN_WORD, 32'h0);
        send_a(MEM_READ,  32'h10, LEN_WORD, 32'h0);
        @(negedge clk);
        n_run++; if (a_rsp_vld !== 1'b1) begin n_fail++; $display("FAIL pending_before_rst got %b want 1", a_rsp_vld); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        n_run++; if (a_rsp_vld !== 1'b0) begin n_fail++; $display("FAIL midrst_rsp_vld got %b want 0", a_rsp_vld); end
        n_run++; if (a_req_rdy !== 1'b0) begin n_fail++; $display("FAIL midrst_req_rdy got %b want 0", a_req_rdy); end
        @(posedge clk); #1;
        rst = 1'b0;
        a_rsp_rdy = 1'b1;
        repeat (5) @(negedge clk);
        n_run++; if (a_rsp_q.size() !== 0) begin n_fail++; $display("FAIL stale_rsp got %0d responses want 0", a_rsp_q.size()); end
        @(posedge clk); #1;
        send_a(MEM_READ, 32'h40, LEN_WORD, 32'h0);
        wait_rsp_a(1);
        n_run++; if (a_rsp_q[0].data !== 32'hCAFEF00D) begin n_fail++; $display("FAIL kept_write got %h want CAFEF00D", a_rsp_q[0].data); end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        clear_logs();
        a_rsp_rdy = 1'b1;
        send_a(MEM_WRITE, 32'h1000, LEN_WORD, 32'h12345678);
        send_a(MEM_READ,  32'h0000, LEN_WORD, 32'h0);
        wait_rsp_a(2);
        n_run++; if (a_rsp_q[1].data !== 32'h12345678) begin n_fail++; $display("FAIL wrap_data got %h want 12345678", a_rsp_q[1].data); end
        n_run++; if (a_rsp_q[1].addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr got %h want 0", a_rsp_q[1].addr); end
        @(posedge clk); #1;
    endtask

    initial begin
        rst       = 1'b1;
        a_req_vld = 1'b0;
        a_rsp_rdy = 1'b1;
        a_req     = '0;
        b_req_vld = 1'b0;
        b_rsp_rdy = 1'b1;
        b_req     = '0;
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_backpressure();
        test_back_to_back();
        test_reset_midflight();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
